register_file_32x32: RTL

- Architectural register file for the single-cycle datapath: 32 registers, each 32 bits wide.
- Two combinational read ports feed the ALU operand path and the ALUSrc 32-bit 2:1 mux.
- One synchronous write port consumes the RegDst 5-bit 2:1 mux output as the destination index.
- It also consumes the MemtoReg 32-bit 2:1 mux output as the write data.
- Register 0 is hardwired to zero.

---
 rtl/register_file_32x32.sv | 128 ++++++++++++
 1 files changed

// File: rtl/register_file_32x32.sv
// ----------------------------------------------------------------------------
// register_file_32x32
//
// Architectural register file for the single-cycle datapath: 32 x 32-bit
// registers, two combinational read ports and one synchronous write port.
// Register 0 is not stored. It always reads as zero, and writes to it are
// discarded.
//
// Parameters
//   BYPASS     0: reads return the stored value only.
//              1: a write in flight is forwarded to a matching read port.
//   RESET_VAL  value loaded into registers 1..31 while rst_n is low.
//
// Ports
//   clk         in   1   datapath clock; writes land on the rising edge
//   rst_n       in   1   asynchronous active-low reset
//   read_reg1   in   5   read port 1 index (rs)
//   read_reg2   in   5   read port 2 index (rt)
//   write_reg   in   5   write index (RegDst mux output)
//   write_data  in   32  write value (MemtoReg mux output)
//   reg_write   in   1   write enable
//   read_data1  out  32  contents of register read_reg1
//   read_data2  out  32  contents of register read_reg2
// ----------------------------------------------------------------------------
module register_file_32x32 #(
  parameter bit          BYPASS    = 1'b0,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        reg_write,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  // Index 0 has no storage. The array starts at 1.
  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];

  // A write is live only for a nonzero index. This condition also gates the
  // bypass path, so forwarding can never apply to register 0.
  logic write_en;
  assign write_en = reg_write && (write_reg != 5'd0);

  // ---------------------------------------------------------------------------
  // Next-state: at most one register takes write_data. All others hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first (hold value), so no latch is inferred.
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (write_en && (write_reg == 5'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Reset forces RESET_VAL asynchronously, and a write in the same
  // cycle as reset is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this storage is reset on purpose; after reset every register must read RESET_VAL, so it is built from flops rather than an unreset RAM.
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. These are pure combinational muxes over the stored registers,
  // with optional forwarding of the write in flight. Outputs are forced to
  // zero while reset is held.
  // ---------------------------------------------------------------------------
  logic [31:0] stored1;
  logic [31:0] stored2;
  logic        fwd1;
  logic        fwd2;

  always_comb begin
    stored1 = 32'h0;
    for (int i = 1; i < 32; i++) begin
      if (read_reg1 == 5'(i)) begin
        stored1 = regs_q[i];
      end
    end
    fwd1 = BYPASS && write_en && (read_reg1 == write_reg);
    if (!rst_n) begin
      read_data1 = 32'h0;
    end else if (fwd1) begin
      read_data1 = write_data;
    end else begin
      read_data1 = stored1;
    end
  end

  always_comb begin
    stored2 = 32'h0;
    for (int i = 1; i < 32; i++) begin
      if (read_reg2 == 5'(i)) begin
        stored2 = regs_q[i];
      end
    end
    fwd2 = BYPASS && write_en && (read_reg2 == write_reg);
    if (!rst_n) begin
      read_data2 = 32'h0;
    end else if (fwd2) begin
      read_data2 = write_data;
    end else begin
      read_data2 = stored2;
    end
  end

  // An unknown write index with the enable set would otherwise be treated
  // as a no-op by the compare logic. Report it instead of hiding it.
  write_reg_known_a : assert property (
    @(posedge clk) disable iff (!rst_n) reg_write |-> !$isunknown(write_reg)
  ) else $error("register_file_32x32: write_reg is unknown while reg_write=1");

endmodule
